tick_period_monitor: RTL and testbench
======================================

Name: tick_period_monitor

Overview:
- Receive-side checker for the periodic one-cycle tick produced by the team's 1 s timer; sits on the consumer side of that tick in the scope datapath.
- Measures the i_clk cycle count between successive tick rising edges and reports each period.
- Flags periods outside a tolerance window and ticks that never arrive, and indicates lock after a run of good periods.

Parameters:
- P_NOMINAL, 5_000_001, expected edge-to-edge period in i_clk cycles.
- P_TOL, 16, allowed deviation in cycles; a period is good when |period − P_NOMINAL| <= P_TOL.
- P_TIMEOUT, 10_000_002, cycle count without an edge that declares the tick lost.
- P_LOCK_N, 4, consecutive good periods required to assert lock.
- P_CNT_W, 26, counter/period width; must satisfy 2^P_CNT_W > P_TIMEOUT.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_tick  in  1  tick input, synchronous to i_clk, any high width >= 1 cycle.
- o_period  out  P_CNT_W  last measured period, held until the next measurement.
- o_period_valid  out  1  one-cycle strobe when o_period updates.
- o_in_window  out  1  window verdict for o_period; valid with o_period_valid, held after.
- o_timeout  out  1  one-cycle strobe when the tick is declared lost.
- o_locked  out  1  level; P_LOCK_N consecutive good periods seen.
- o_err_cnt  out  8  count of bad periods plus timeouts, saturating at 255.

Behaviour:
- Reset (async, i_rst=1):
  - All outputs 0; state S_IDLE; counter 0; good-run count 0; edge register 0.
- Edge detect:
  - edge = i_tick & ~r_tick_d, where r_tick_d is i_tick registered.
  - A tick held high counts as one edge.
  - If i_tick is 1 on the first cycle after reset, that cycle counts as an edge.
- S_IDLE:
  - Counter held at 0.
  - On edge: go to S_RUN and load counter = 1.
  - No period is reported for this first edge.
- S_RUN, counting:
  - Counter increments by 1 every cycle.
  - Counter value N at the cycle of an edge equals that edge's distance in cycles from the previous edge.
- S_RUN, on edge:
  - Next cycle: o_period = N, o_period_valid = 1 for one cycle, o_in_window = (|N − P_NOMINAL| <= P_TOL).
  - Counter reloads to 1 and state stays S_RUN.
  - Latency is 1 cycle from the edge cycle to the strobe.
  - Compute the window check with unsigned compares (N >= P_NOMINAL−P_TOL and N <= P_NOMINAL+P_TOL); no signed arithmetic.
- Good/bad tracking:
  - Good period: good-run count increments, saturating at P_LOCK_N. o_locked = 1 once the count reaches P_LOCK_N, asserted in the same cycle as the strobe.
  - Bad period: good-run count = 0, o_locked = 0, o_err_cnt increments.
- Timeout, S_RUN with counter == P_TIMEOUT and no edge this cycle:
  - Next cycle: o_timeout = 1 for one cycle.
  - o_locked = 0, good-run count = 0, o_err_cnt increments.
  - State goes to S_IDLE, counter = 0.
  - o_period and o_in_window keep their last values.
- Simultaneous edge and counter == P_TIMEOUT:
  - The edge wins: the period is reported (it is out of window, so counted as bad), and there is no timeout.
- Never, in any state:
  - The counter never wraps.
  - o_period_valid and o_timeout are never high in the same cycle.
- o_err_cnt is saturating: stays at 255 and does not roll over.
- Reset mid-measurement:
  - Immediate return to reset values; the next edge after deassertion is treated as a first edge (no report).

Test Plan (sim overrides: P_NOMINAL=10, P_TOL=1, P_TIMEOUT=20, P_LOCK_N=3, P_CNT_W=6):
- Ticks every 10 cycles, 5 ticks -> 4 strobes with o_period=10 and o_in_window=1; o_locked rises with the 3rd strobe; o_err_cnt=0.
- Periods 10,10,10,12,10 -> 4th strobe has o_period=12, o_in_window=0; o_locked falls with that strobe; o_err_cnt=1; lock returns 3 good periods later.
- Locked, then tick stopped -> o_timeout pulses exactly 21 cycles after the last edge (counter hits 20 one cycle before); o_locked=0; o_err_cnt+1; the next tick gives no strobe, the following tick gives a strobe.
- Tick at exactly 20 cycles -> strobe with o_period=20, o_in_window=0; no o_timeout.
- Tick held high for 4 cycles at a 10-cycle spacing -> one edge per tick; o_period=10.
- i_rst pulsed mid-count, and separately 300 bad periods -> all outputs 0 immediately and the first post-reset tick gives no strobe; o_err_cnt stops at 255.

Source files
------------

// File: rtl/tick_period_monitor.sv
// tick_period_monitor
// Consumer-side checker for the periodic one-cycle tick from the 1 s timer.
// Measures the i_clk cycle count between successive tick rising edges,
// reports every period with a window verdict, flags lost ticks, tracks lock
// after a run of good periods and keeps a saturating error count.

module tick_period_monitor #(
    parameter int unsigned P_NOMINAL = 5_000_001,
    parameter int unsigned P_TOL     = 16,
    parameter int unsigned P_TIMEOUT = 10_000_002,
    parameter int unsigned P_LOCK_N  = 4,
    parameter int unsigned P_CNT_W   = 26
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tick,
    output logic [P_CNT_W-1:0] o_period,
    output logic               o_period_valid,
    output logic               o_in_window,
    output logic               o_timeout,
    output logic               o_locked,
    output logic [7:0]         o_err_cnt
);

    // Window bounds; the low bound clamps at zero so small nominals stay valid.
    localparam int unsigned WIN_LO_I = (P_NOMINAL > P_TOL) ? (P_NOMINAL - P_TOL) : 0;
    localparam int unsigned WIN_HI_I = P_NOMINAL + P_TOL;

    localparam logic [P_CNT_W-1:0] WIN_LO    = P_CNT_W'(WIN_LO_I);
    localparam logic [P_CNT_W-1:0] WIN_HI    = P_CNT_W'(WIN_HI_I);
    localparam logic [P_CNT_W-1:0] TIMEOUT_V = P_CNT_W'(P_TIMEOUT);
    localparam logic [P_CNT_W-1:0] CNT_ONE   = P_CNT_W'(1);

    // Good-run counter only needs to reach P_LOCK_N before it saturates.
    localparam int unsigned       GOOD_W   = $clog2(P_LOCK_N + 1);
    localparam logic [GOOD_W-1:0] LOCK_N_V = GOOD_W'(P_LOCK_N);
    localparam logic [GOOD_W-1:0] GOOD_ONE = GOOD_W'(1);

    localparam logic [7:0] ERR_MAX = 8'hFF;
    localparam logic [7:0] ERR_ONE = 8'h01;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t state;
    state_t state_next;

    logic               tick_d;
    logic               tick_edge;
    logic [P_CNT_W-1:0] cnt;
    logic [P_CNT_W-1:0] cnt_next;
    logic               report;
    logic               timeout_hit;
    logic               in_window_now;
    logic [GOOD_W-1:0]  good_cnt;
    logic [GOOD_W-1:0]  good_next;

    // Delayed copy of the tick; reset to 0 so a tick already high at
    // reset release is seen as an edge on the first cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tick_d <= 1'b0;
        end else begin
            tick_d <= i_tick;
        end
    end

    assign tick_edge = i_tick & ~tick_d;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: first edge arms the measurement, a lost tick disarms it.
    // An edge on the timeout cycle wins, so the run continues.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (tick_edge) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (!tick_edge && (cnt == TIMEOUT_V)) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode: period report on an edge while running, timeout when the
    // counter reaches its limit without an edge, and the next counter value.
    // The counter stops at P_TIMEOUT (reload or clear), so it never wraps.
    always_comb begin
        report      = 1'b0;
        timeout_hit = 1'b0;
        cnt_next    = cnt;
        case (state)
            S_IDLE: begin
                cnt_next = tick_edge ? CNT_ONE : '0;
            end
            S_RUN: begin
                if (tick_edge) begin
                    report   = 1'b1;
                    cnt_next = CNT_ONE;
                end else if (cnt == TIMEOUT_V) begin
                    timeout_hit = 1'b1;
                    cnt_next    = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: cnt_next = '0;
        endcase
    end

    // Window verdict and saturating good-run increment for the current count.
    always_comb begin
        in_window_now = (cnt >= WIN_LO) && (cnt <= WIN_HI);
        if (good_cnt >= LOCK_N_V) begin
            good_next = LOCK_N_V;
        end else begin
            good_next = good_cnt + GOOD_ONE;
        end
    end

    // Cycle counter between edges.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    // Period result registers: strobes last one cycle, period and verdict hold.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_period       <= '0;
            o_period_valid <= 1'b0;
            o_in_window    <= 1'b0;
            o_timeout      <= 1'b0;
        end else begin
            o_period_valid <= report;
            o_timeout      <= timeout_hit;
            if (report) begin
                o_period    <= cnt;
                o_in_window <= in_window_now;
            end
        end
    end

    // Lock and error tracking; bad periods and timeouts both break lock.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            good_cnt  <= '0;
            o_locked  <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            if (report && in_window_now) begin
                good_cnt <= good_next;
                o_locked <= (good_next == LOCK_N_V);
            end else if (report || timeout_hit) begin
                good_cnt <= '0;
                o_locked <= 1'b0;
                if (o_err_cnt != ERR_MAX) begin
                    o_err_cnt <= o_err_cnt + ERR_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_period_monitor.sv
// Directed bench for tick_period_monitor using small sim parameters:
// nominal 10, tolerance 1, timeout 20, lock after 3 good periods.

module tb_tick_period_monitor;

    localparam int unsigned W = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick;
    logic [W-1:0] o_period;
    logic         o_period_valid;
    logic         o_in_window;
    logic         o_timeout;
    logic         o_locked;
    logic [7:0]   o_err_cnt;

    int checks  = 0;
    int errors  = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    tick_period_monitor #(
        .P_NOMINAL(10),
        .P_TOL    (1),
        .P_TIMEOUT(20),
        .P_LOCK_N (3),
        .P_CNT_W  (W)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_tick        (tick),
        .o_period      (o_period),
        .o_period_valid(o_period_valid),
        .o_in_window   (o_in_window),
        .o_timeout     (o_timeout),
        .o_locked      (o_locked),
        .o_err_cnt     (o_err_cnt)
    );

    // The two strobes must never coincide.
    always @(negedge clk) begin
        if (o_period_valid && o_timeout) overlap++;
    end

    // One record per tick edge: tick is high for 'width' cycles starting at
    // step 1, the next record's edge comes 'gap' cycles later. Expected
    // values are those sampled just after the edge is registered.
    typedef struct {
        int unsigned width;
        int unsigned gap;
        logic        exp_valid;
        int unsigned exp_period;
        logic        exp_win;
        logic        exp_locked;
        int unsigned exp_err;
        int unsigned to_step;   // step at which o_timeout must pulse, 0 = never
    } vec_t;

    vec_t vecs[19];
    vec_t va;
    vec_t vb;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        int unsigned stray;
        int unsigned to_at;
        stray = 0;
        to_at = 0;
        for (int unsigned s = 1; s <= v.gap; s++) begin
            tick = (s <= v.width);
            step();
            if (s == 1) begin
                check({tag, " valid"},  32'(o_period_valid), 32'(v.exp_valid));
                check({tag, " period"}, 32'(o_period),       v.exp_period);
                check({tag, " win"},    32'(o_in_window),    32'(v.exp_win));
                check({tag, " locked"}, 32'(o_locked),       32'(v.exp_locked));
                check({tag, " err"},    32'(o_err_cnt),      v.exp_err);
            end else if (o_period_valid) begin
                stray++;
            end
            if (o_timeout) begin
                if (to_at == 0) to_at = s;
                else stray++;
            end
        end
        check({tag, " timeout_step"}, to_at, v.to_step);
        check({tag, " stray_strobes"}, stray, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // width gap valid period win locked err to_step
        vecs[0]  = '{1, 10, 1'b0,  0, 1'b0, 1'b0, 0,  0};  // first edge, no report
        vecs[1]  = '{1, 10, 1'b1, 10, 1'b1, 1'b0, 0,  0};
        vecs[2]  = '{1, 10, 1'b1, 10, 1'b1, 1'b0, 0,  0};
        vecs[3]  = '{1, 10, 1'b1, 10, 1'b1, 1'b1, 0,  0};  // lock with 3rd strobe
        vecs[4]  = '{1, 12, 1'b1, 10, 1'b1, 1'b1, 0,  0};
        vecs[5]  = '{1, 10, 1'b1, 12, 1'b0, 1'b0, 1,  0};  // 12 out of window
        vecs[6]  = '{1, 10, 1'b1, 10, 1'b1, 1'b0, 1,  0};
        vecs[7]  = '{1, 10, 1'b1, 10, 1'b1, 1'b0, 1,  0};
        vecs[8]  = '{1, 25, 1'b1, 10, 1'b1, 1'b1, 1, 21};  // relock, then tick lost
        vecs[9]  = '{1, 10, 1'b0, 10, 1'b1, 1'b0, 2,  0};  // first edge after timeout
        vecs[10] = '{1, 20, 1'b1, 10, 1'b1, 1'b0, 2,  0};
        vecs[11] = '{1, 10, 1'b1, 20, 1'b0, 1'b0, 3,  0};  // edge at timeout count
        vecs[12] = '{4, 10, 1'b1, 10, 1'b1, 1'b0, 3,  0};  // wide ticks
        vecs[13] = '{4, 10, 1'b1, 10, 1'b1, 1'b0, 3,  0};
        vecs[14] = '{4,  9, 1'b1, 10, 1'b1, 1'b1, 3,  0};
        vecs[15] = '{1, 11, 1'b1,  9, 1'b1, 1'b1, 3,  0};  // low edge of window
        vecs[16] = '{1,  8, 1'b1, 11, 1'b1, 1'b1, 3,  0};  // high edge of window
        vecs[17] = '{1, 10, 1'b1,  8, 1'b0, 1'b0, 4,  0};  // just below window
        vecs[18] = '{1, 10, 1'b1, 10, 1'b1, 1'b0, 4,  0};

        rst  = 1'b1;
        tick = 1'b0;
        step();
        step();
        check("rst period",  32'(o_period),       0);
        check("rst valid",   32'(o_period_valid), 0);
        check("rst win",     32'(o_in_window),    0);
        check("rst timeout", 32'(o_timeout),      0);
        check("rst locked",  32'(o_locked),       0);
        check("rst err",     32'(o_err_cnt),      0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-count clears everything without a clock edge.
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check("arst period", 32'(o_period),    0);
        check("arst win",    32'(o_in_window), 0);
        check("arst err",    32'(o_err_cnt),   0);
        check("arst locked", 32'(o_locked),    0);
        check("arst valid",  32'(o_period_valid), 0);
        // Tick already high on the first cycle after release counts as an edge.
        tick = 1'b1;
        step();
        rst = 1'b0;
        va = '{1, 10, 1'b0,  0, 1'b0, 1'b0, 0, 0};
        vb = '{1,  5, 1'b1, 10, 1'b1, 1'b0, 0, 0};
        apply_vec(va, "post_rst0");
        apply_vec(vb, "post_rst1");

        // 300 consecutive bad periods: error count saturates at 255.
        for (int k = 1; k <= 300; k++) begin
            tick = 1'b1;
            step();
            if (k == 254) check("err_254", 32'(o_err_cnt), 254);
            if (k == 256) check("err_sat", 32'(o_err_cnt), 255);
            tick = 1'b0;
            for (int j = 0; j < 4; j++) step();
        end
        check("err_final",    32'(o_err_cnt),   255);
        check("sat period",   32'(o_period),    5);
        check("sat win",      32'(o_in_window), 0);
        check("sat locked",   32'(o_locked),    0);
        check("strobe_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
